// File: rtl/aqed_pkg.sv
// Shared types for the A-QED duplicate issuer and its output-side checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aqed_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_CNT_WIDTH  = 16;

  // Issuer progress: nothing captured, original held, duplicate issued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    DONE = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/aqed_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Latency: count updates one cycle after inc; sat is decoded from the count.
// Backpressure: inc is ignored once saturated; the counter never wraps.
module aqed_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 sat
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next count: advance on inc unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = &cnt_q;

endmodule

// File: rtl/aqed_dup_issuer.sv
// Forwards the BMC stream to memory_core, captures one original and re-inserts it once.
// Latency: 0 cycles for forwarding/insertion; indices and flags register on the accepting edge.
// Backpressure: acc_full or counter saturation stalls the stream; an insertion also stalls the BMC word.
module aqed_dup_issuer
  import aqed_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int MIN_GAP    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bmc_in_dat,
  input  logic                  bmc_in_v,
  output logic                  bmc_in_rdy,
  input  logic                  exec_dup,
  input  logic                  acc_full,
  output logic [DATA_WIDTH-1:0] acc_data_in,
  output logic                  acc_wen,
  output logic                  orig_issued,
  output logic                  dup_issued,
  output logic                  insert_cond,
  output logic [CNT_WIDTH-1:0]  orig_idx,
  output logic [CNT_WIDTH-1:0]  dup_idx,
  output logic [DATA_WIDTH-1:0] orig_val,
  output logic [CNT_WIDTH-1:0]  issue_cnt,
  output logic                  cnt_sat
);

  localparam logic [CNT_WIDTH-1:0] MIN_GAP_C = CNT_WIDTH'(MIN_GAP);

  issuer_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0]  orig_idx_q, orig_idx_d;
  logic [CNT_WIDTH-1:0]  dup_idx_q, dup_idx_d;
  logic [DATA_WIDTH-1:0] orig_val_q, orig_val_d;
  logic                  orig_issued_q, orig_issued_d;
  logic                  dup_issued_q, dup_issued_d;

  logic                  can_write;
  logic [CNT_WIDTH-1:0]  gap;
  logic                  ins_ok;
  logic                  capture;

  // Write slot exists only out of reset, with room downstream and counter headroom.
  assign can_write = reset && !acc_full && !cnt_sat;
  assign gap       = issue_cnt - orig_idx_q;
  assign ins_ok    = (state_q == HELD) && exec_dup && can_write && (gap >= MIN_GAP_C);
  assign capture   = (state_q == IDLE) && exec_dup && bmc_in_v && can_write;

  aqed_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_issue_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (acc_wen),
    .cnt   (issue_cnt),
    .sat   (cnt_sat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: capture moves to HELD, insertion moves to DONE, DONE is terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = HELD;
      HELD:    if (ins_ok)  state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output mux: an insertion takes the write port and blocks the BMC word.
  always_comb begin
    insert_cond = ins_ok;
    acc_wen     = ins_ok || (bmc_in_v && can_write);
    bmc_in_rdy  = !ins_ok && bmc_in_v && can_write;
    acc_data_in = ins_ok ? orig_val_q : bmc_in_dat;
  end

  // Capture registers: record the original on capture, the duplicate index on insertion.
  always_comb begin
    orig_idx_d    = orig_idx_q;
    dup_idx_d     = dup_idx_q;
    orig_val_d    = orig_val_q;
    orig_issued_d = orig_issued_q;
    dup_issued_d  = dup_issued_q;
    if (capture) begin
      orig_idx_d    = issue_cnt;
      orig_val_d    = bmc_in_dat;
      orig_issued_d = 1'b1;
    end
    if (ins_ok) begin
      dup_idx_d    = issue_cnt;
      dup_issued_d = 1'b1;
    end
  end

  // Capture register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      orig_idx_q    <= '0;
      dup_idx_q     <= '0;
      orig_val_q    <= '0;
      orig_issued_q <= 1'b0;
      dup_issued_q  <= 1'b0;
    end else begin
      orig_idx_q    <= orig_idx_d;
      dup_idx_q     <= dup_idx_d;
      orig_val_q    <= orig_val_d;
      orig_issued_q <= orig_issued_d;
      dup_issued_q  <= dup_issued_d;
    end
  end

  assign orig_idx    = orig_idx_q;
  assign dup_idx     = dup_idx_q;
  assign orig_val    = orig_val_q;
  assign orig_issued = orig_issued_q;
  assign dup_issued  = dup_issued_q;

endmodule

// File: tb/tb_aqed_dup_issuer.sv
// Directed bench for aqed_dup_issuer: default instance plus a 3-bit counter instance.
// Latency: inputs change 1 time unit after posedge; outputs sampled 1 unit later or after the next edge.
// Backpressure: acc_full and counter saturation exercised directly.
module tb_aqed_dup_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bmc_in_dat;
  logic        bmc_in_v;
  logic        exec_dup;
  logic        acc_full;

  logic        bmc_in_rdy, acc_wen, orig_issued, dup_issued, insert_cond, cnt_sat;
  logic [15:0] acc_data_in, orig_idx, dup_idx, orig_val, issue_cnt;

  logic        bmc_in_rdy3, acc_wen3, orig_issued3, dup_issued3, insert_cond3, cnt_sat3;
  logic [15:0] acc_data_in3, orig_val3;
  logic [2:0]  orig_idx3, dup_idx3, issue_cnt3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aqed_dup_issuer dut (
    .clk         (clk),
    .reset       (reset),
    .bmc_in_dat  (bmc_in_dat),
    .bmc_in_v    (bmc_in_v),
    .bmc_in_rdy  (bmc_in_rdy),
    .exec_dup    (exec_dup),
    .acc_full    (acc_full),
    .acc_data_in (acc_data_in),
    .acc_wen     (acc_wen),
    .orig_issued (orig_issued),
    .dup_issued  (dup_issued),
    .insert_cond (insert_cond),
    .orig_idx    (orig_idx),
    .dup_idx     (dup_idx),
    .orig_val    (orig_val),
    .issue_cnt   (issue_cnt),
    .cnt_sat     (cnt_sat)
  );

  aqed_dup_issuer #(.DATA_WIDTH(16), .CNT_WIDTH(3), .MIN_GAP(1)) dut3 (
    .clk         (clk),
    .reset       (reset),
    .bmc_in_dat  (bmc_in_dat),
    .bmc_in_v    (bmc_in_v),
    .bmc_in_rdy  (bmc_in_rdy3),
    .exec_dup    (exec_dup),
    .acc_full    (acc_full),
    .acc_data_in (acc_data_in3),
    .acc_wen     (acc_wen3),
    .orig_issued (orig_issued3),
    .dup_issued  (dup_issued3),
    .insert_cond (insert_cond3),
    .orig_idx    (orig_idx3),
    .dup_idx     (dup_idx3),
    .orig_val    (orig_val3),
    .issue_cnt   (issue_cnt3),
    .cnt_sat     (cnt_sat3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    bmc_in_v   = 1'b1;
    bmc_in_dat = 16'h0000;
    exec_dup   = 1'b0;
    acc_full   = 1'b0;

    // 1. reset held two cycles with a valid word, then forwarding and counting
    tick();
    tick();
    check("rst_wen",        32'(acc_wen),     32'd0);
    check("rst_rdy",        32'(bmc_in_rdy),  32'd0);
    check("rst_insert",     32'(insert_cond), 32'd0);
    check("rst_cnt",        32'(issue_cnt),   32'd0);
    check("rst_orig_idx",   32'(orig_idx),    32'd0);
    check("rst_dup_idx",    32'(dup_idx),     32'd0);
    check("rst_orig_val",   32'(orig_val),    32'd0);
    check("rst_orig_iss",   32'(orig_issued), 32'd0);
    check("rst_dup_iss",    32'(dup_issued),  32'd0);
    check("rst_sat",        32'(cnt_sat),     32'd0);
    reset      = 1'b1;
    bmc_in_dat = 16'hAAAA;
    #1;
    check("fwd_wen",  32'(acc_wen),     32'd1);
    check("fwd_rdy",  32'(bmc_in_rdy),  32'd1);
    check("fwd_data", 32'(acc_data_in), 32'hAAAA);
    tick();
    check("cnt_1", 32'(issue_cnt), 32'd1);
    tick();
    check("cnt_2", 32'(issue_cnt), 32'd2);
    tick();
    check("cnt_3", 32'(issue_cnt), 32'd3);

    // 2. capture 0x0022 at index 1, insert it at index 3, 0x0044 follows at index 4
    do_reset();
    bmc_in_dat = 16'h0011; exec_dup = 1'b0;
    tick();
    bmc_in_dat = 16'h0022; exec_dup = 1'b1;
    tick();
    check("cap_orig_idx", 32'(orig_idx),    32'd1);
    check("cap_orig_val", 32'(orig_val),    32'h0022);
    check("cap_orig_iss", 32'(orig_issued), 32'd1);
    check("cap_cnt",      32'(issue_cnt),   32'd2);
    bmc_in_dat = 16'h0033; exec_dup = 1'b0;
    #1;
    check("held_fwd_data", 32'(acc_data_in), 32'h0033);
    check("held_no_ins",   32'(insert_cond), 32'd0);
    tick();
    bmc_in_dat = 16'h0044; exec_dup = 1'b1;
    #1;
    check("ins_cond", 32'(insert_cond), 32'd1);
    check("ins_data", 32'(acc_data_in), 32'h0022);
    check("ins_rdy",  32'(bmc_in_rdy),  32'd0);
    check("ins_wen",  32'(acc_wen),     32'd1);
    tick();
    check("ins_dup_idx", 32'(dup_idx),    32'd3);
    check("ins_dup_iss", 32'(dup_issued), 32'd1);
    check("ins_cnt",     32'(issue_cnt),  32'd4);
    exec_dup = 1'b0;
    #1;
    check("after_data", 32'(acc_data_in), 32'h0044);
    check("after_rdy",  32'(bmc_in_rdy),  32'd1);
    tick();
    check("after_cnt", 32'(issue_cnt), 32'd5);
    exec_dup   = 1'b1;
    bmc_in_dat = 16'h0055;
    #1;
    check("done_no_ins",   32'(insert_cond), 32'd0);
    check("done_fwd_data", 32'(acc_data_in), 32'h0055);
    tick();
    check("done_dup_idx", 32'(dup_idx),   32'd3);
    check("done_cnt",     32'(issue_cnt), 32'd6);

    // 3. minimum gap: duplicate on the cycle right after capture
    do_reset();
    bmc_in_dat = 16'h0100; exec_dup = 1'b1;
    tick();
    check("gap_orig_idx", 32'(orig_idx), 32'd0);
    bmc_in_dat = 16'h0101;
    #1;
    check("gap_ins",  32'(insert_cond), 32'd1);
    check("gap_data", 32'(acc_data_in), 32'h0100);
    tick();
    check("gap_dup_idx", 32'(dup_idx),   32'd1);
    check("gap_cnt",     32'(issue_cnt), 32'd2);

    // 4. acc_full drops the insertion request; it succeeds on the next exec_dup
    do_reset();
    bmc_in_dat = 16'h0200; exec_dup = 1'b1;
    tick();
    acc_full = 1'b1;
    #1;
    check("full_wen", 32'(acc_wen),     32'd0);
    check("full_rdy", 32'(bmc_in_rdy),  32'd0);
    check("full_ins", 32'(insert_cond), 32'd0);
    tick();
    check("full_cnt",     32'(issue_cnt),   32'd1);
    check("full_dup_iss", 32'(dup_issued),  32'd0);
    check("full_orig",    32'(orig_issued), 32'd1);
    acc_full = 1'b0;
    #1;
    check("unfull_ins", 32'(insert_cond), 32'd1);
    tick();
    check("unfull_dup_idx", 32'(dup_idx),    32'd1);
    check("unfull_dup_iss", 32'(dup_issued), 32'd1);
    check("unfull_cnt",     32'(issue_cnt),  32'd2);

    // 5. 3-bit counter: original at index 6, saturation blocks the duplicate
    do_reset();
    exec_dup   = 1'b0;
    bmc_in_dat = 16'h0300;
    repeat (6) tick();
    check("sat_pre_cnt", 32'(issue_cnt3), 32'd6);
    check("sat_pre_sat", 32'(cnt_sat3),   32'd0);
    exec_dup   = 1'b1;
    bmc_in_dat = 16'h0366;
    tick();
    check("sat_cnt",      32'(issue_cnt3),   32'd7);
    check("sat_flag",     32'(cnt_sat3),     32'd1);
    check("sat_orig_idx", 32'(orig_idx3),    32'd6);
    check("sat_orig_val", 32'(orig_val3),    32'h0366);
    check("sat_orig_iss", 32'(orig_issued3), 32'd1);
    #1;
    check("sat_wen",  32'(acc_wen3),     32'd0);
    check("sat_rdy",  32'(bmc_in_rdy3),  32'd0);
    check("sat_ins",  32'(insert_cond3), 32'd0);
    check("sat_data", 32'(acc_data_in3), 32'h0366);
    tick();
    check("sat_dup_iss",  32'(dup_issued3), 32'd0);
    check("sat_dup_idx",  32'(dup_idx3),    32'd0);
    check("sat_cnt_hold", 32'(issue_cnt3),  32'd7);

    // 6. reset while HELD clears everything; a new capture starts from index 0
    do_reset();
    bmc_in_dat = 16'h0400; exec_dup = 1'b1;
    tick();
    check("h_orig_iss", 32'(orig_issued), 32'd1);
    exec_dup = 1'b0;
    reset    = 1'b0;
    tick();
    check("hr_orig_iss", 32'(orig_issued), 32'd0);
    check("hr_cnt",      32'(issue_cnt),   32'd0);
    check("hr_orig_val", 32'(orig_val),    32'd0);
    reset      = 1'b1;
    exec_dup   = 1'b1;
    bmc_in_dat = 16'h0401;
    #1;
    check("hr_no_ins", 32'(insert_cond), 32'd0);
    tick();
    check("new_orig_idx", 32'(orig_idx),    32'd0);
    check("new_orig_val", 32'(orig_val),    32'h0401);
    check("new_orig_iss", 32'(orig_issued), 32'd1);
    check("new_dup_iss",  32'(dup_issued),  32'd0);
    check("new_cnt",      32'(issue_cnt),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
